segment7_ascii: RTL and testbench
=================================

Name: segment7_ascii

Overview:
Registered decoder that converts a 7-segment display pattern into the ASCII code of the character it shows. It sits between a segment-pattern source (a display-scan capture or character generator) and text/debug logic that needs printable characters. Decoding is table-based, with one clock of latency and a flag for patterns that are not recognised.

Parameters:
ACTIVE_LOW, 0, when 1 the seg input is inverted before decode (common-anode patterns, where 0 = lit); when 0, 1 = lit segment.
UNKNOWN_CHAR, 8'h3F, ASCII code output for unrecognised patterns ('?').

Ports:
clk  input  1  system clock, rising-edge active.
rst_n  input  1  asynchronous active-low reset.
en  input  1  sample enable; outputs update only on cycles where en=1.
seg  input  7  segment pattern, bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
ascii  output  8  decoded ASCII code, registered.
known  output  1  1 when the last sampled pattern matched the decode table, registered.

Behaviour:
- Reset: rst_n=0 asynchronously forces ascii=8'h00 and known=0; the outputs hold these values until the first enabled clock edge after release.
- Latency: pattern p is sampled on the rising edge where en=1. ascii and known reflect p immediately after that edge (1 cycle). With en=0 the outputs hold their values.
- Normalisation: if ACTIVE_LOW=1, the table is applied to ~seg; otherwise it is applied to seg.
- Decode table, normalised pattern (g..a) -> ASCII:
  - Digits: 0111111->'0'(30), 0000110->'1'(31), 1011011->'2'(32), 1001111->'3'(33), 1100110->'4'(34), 1101101->'5'(35), 1111101->'6'(36), 0000111->'7'(37), 0100111->'7'(37), 1111111->'8'(38), 1101111->'9'(39), 1100111->'9'(39).
  - Hex letters: 1110111->'A'(41), 1111100->'b'(62), 0111001->'C'(43), 1011110->'d'(64), 1111001->'E'(45), 1110001->'F'(46).
  - Symbols: 0000000->' '(20), 1000000->'-'(2D), 0001000->'_'(5F).
- Every table hit sets known=1.
- Any other pattern gives ascii=UNKNOWN_CHAR and known=0.
- The output is always a full 8-bit code with the MSB always 0. No X propagation: an unknown pattern never leaves the outputs undriven.
- Reset asserted mid-operation overrides en and any pending sample immediately, without waiting for a clock edge.
- Back-to-back enabled samples are allowed every cycle; each one replaces the previous result.

Test Plan:
- Reset: rst_n=0 with seg=7'b1111111 and clocks running -> ascii=8'h00 and known=0 throughout reset; both hold until the first en=1 edge after release.
- Directed sequence, ACTIVE_LOW=0, en=1: seg=7'b0111111 -> next cycle ascii=8'h30; seg=7'b1111111 -> ascii=8'h38; seg=7'b1001111 -> ascii=8'h33; known=1 for all three.
- Full table sweep: apply all 128 patterns, 1 per cycle -> each table entry gives its listed code with known=1; every other pattern gives 8'h3F with known=0.
- Enable hold: after seg=7'b0000110 is decoded ('1'), set en=0 and change seg to 7'b1011011 -> ascii stays 8'h31; set en=1 -> next cycle ascii=8'h32.
- ACTIVE_LOW=1 instance: seg=7'b1000000 (normalises to 0111111) -> ascii=8'h30 and known=1; seg=7'b1111111 (blank) -> ascii=8'h20.
- Async reset mid-stream: while ascii=8'h38, pulse rst_n low between clock edges -> ascii=8'h00 and known=0 without waiting for a clock edge.

Source files
------------

// File: rtl/segment7_ascii.sv
// Converts a 7-segment pattern (bit0=a .. bit6=g) into the ASCII code of the character it shows.
// Latency: 1 cycle; the result is visible right after the rising edge that samples it with en=1.
// No backpressure: a sample is accepted on every en=1 edge, and en=0 holds the last result.
module segment7_ascii #(
    parameter bit         ACTIVE_LOW   = 1'b0,
    parameter logic [7:0] UNKNOWN_CHAR = 8'h3F
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [6:0] seg,
    output logic [7:0] ascii,
    output logic       known
);

    // Common-anode sources drive 0 for a lit segment, so flip them to lit=1 before lookup.
    logic [6:0] pat;
    assign pat = ACTIVE_LOW ? ~seg : seg;

    // {hit, code} from the lookup table.
    logic [8:0] dec;

    // Table lookup. The miss code has bit 7 cleared so the output stays 7-bit ASCII
    // even if UNKNOWN_CHAR is overridden with a wider value.
    always_comb begin
        dec = {1'b0, 1'b0, UNKNOWN_CHAR[6:0]};
        case (pat)
            7'b0111111: dec = {1'b1, 8'h30};
            7'b0000110: dec = {1'b1, 8'h31};
            7'b1011011: dec = {1'b1, 8'h32};
            7'b1001111: dec = {1'b1, 8'h33};
            7'b1100110: dec = {1'b1, 8'h34};
            7'b1101101: dec = {1'b1, 8'h35};
            7'b1111101: dec = {1'b1, 8'h36};
            7'b0000111: dec = {1'b1, 8'h37};
            7'b0100111: dec = {1'b1, 8'h37};
            7'b1111111: dec = {1'b1, 8'h38};
            7'b1101111: dec = {1'b1, 8'h39};
            7'b1100111: dec = {1'b1, 8'h39};
            7'b1110111: dec = {1'b1, 8'h41};
            7'b1111100: dec = {1'b1, 8'h62};
            7'b0111001: dec = {1'b1, 8'h43};
            7'b1011110: dec = {1'b1, 8'h64};
            7'b1111001: dec = {1'b1, 8'h45};
            7'b1110001: dec = {1'b1, 8'h46};
            7'b0000000: dec = {1'b1, 8'h20};
            7'b1000000: dec = {1'b1, 8'h2D};
            7'b0001000: dec = {1'b1, 8'h5F};
            default:    dec = {1'b0, 1'b0, UNKNOWN_CHAR[6:0]};
        endcase
    end

    // Output register: capture the decoded result on enabled edges, clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ascii <= 8'h00;
            known <= 1'b0;
        end else if (en) begin
            ascii <= dec[7:0];
            known <= dec[8];
        end
    end

endmodule

// File: tb/tb_segment7_ascii.sv
// Scoreboard bench for segment7_ascii: stimulus pushes expected {known, ascii} into a queue,
// a monitor pops it one cycle after each enabled sample and checks both polarity instances.
// The active-low instance always sees the inverted pattern, so both must report the same result.
module tb_segment7_ascii;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [6:0] seg0 = 7'b1111111;
    logic [6:0] seg1;
    logic [7:0] ascii0, ascii1;
    logic       known0, known1;

    assign seg1 = ~seg0;

    segment7_ascii #(.ACTIVE_LOW(1'b0), .UNKNOWN_CHAR(8'h3F)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .seg(seg0), .ascii(ascii0), .known(known0)
    );

    segment7_ascii #(.ACTIVE_LOW(1'b1), .UNKNOWN_CHAR(8'h3F)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .seg(seg1), .ascii(ascii1), .known(known1)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] expq[$];
    logic [8:0] cur = 9'h000;
    logic       smp = 1'b0;

    // Hand-written table of recognised patterns (g..a) and their codes.
    logic [6:0] tpat [21] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                              7'b1101101, 7'b1111101, 7'b0000111, 7'b0100111, 7'b1111111,
                              7'b1101111, 7'b1100111, 7'b1110111, 7'b1111100, 7'b0111001,
                              7'b1011110, 7'b1111001, 7'b1110001, 7'b0000000, 7'b1000000,
                              7'b0001000};
    logic [7:0] tcode[21] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34,
                              8'h35, 8'h36, 8'h37, 8'h37, 8'h38,
                              8'h39, 8'h39, 8'h41, 8'h62, 8'h43,
                              8'h64, 8'h45, 8'h46, 8'h20, 8'h2D,
                              8'h5F};

    function automatic logic [8:0] model(input logic [6:0] p);
        logic [8:0] r;
        r = {1'b0, 8'h3F};
        for (int i = 0; i < 21; i++)
            if (tpat[i] == p) r = {1'b1, tcode[i]};
        return r;
    endfunction

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got known=%b ascii=%h, expected known=%b ascii=%h @%0t",
                     name, act[8], act[7:0], exp[8], exp[7:0], $time);
        end
    endtask

    // Record whether the DUT took a sample on this edge.
    always @(posedge clk) smp <= en && rst_n;

    // Asynchronous reset clears the expected outputs immediately.
    always @(negedge rst_n) cur = 9'h000;

    // Monitor: away from the active edge, retire one expectation per sample and check both DUTs.
    always @(negedge clk) begin
        if (!rst_n) begin
            cur = 9'h000;
        end else if (smp) begin
            if (expq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_underflow: sample seen with no expectation @%0t", $time);
            end else begin
                cur = expq.pop_front();
            end
        end
        chk("dut_al0", {known0, ascii0}, cur);
        chk("dut_al1", {known1, ascii1}, cur);
    end

    task automatic sample(input logic [6:0] p, input logic [8:0] exp);
        @(posedge clk);
        #1;
        seg0 = p;
        en   = 1'b1;
        expq.push_back(exp);
    endtask

    task automatic idle(input int n, input logic [6:0] p);
        @(posedge clk);
        #1;
        seg0 = p;
        en   = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    initial begin
        // Reset with an all-lit pattern and en high: outputs must stay cleared.
        repeat (4) @(posedge clk);
        #1;
        en    = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Directed digits.
        sample(7'b0111111, {1'b1, 8'h30});
        sample(7'b1111111, {1'b1, 8'h38});
        sample(7'b1001111, {1'b1, 8'h33});

        // Enable hold: '1' must persist while en=0 even though seg changes.
        sample(7'b0000110, {1'b1, 8'h31});
        idle(4, 7'b1011011);
        sample(7'b1011011, {1'b1, 8'h32});

        // Symbols and a few unknowns by hand.
        sample(7'b0000000, {1'b1, 8'h20});
        sample(7'b1000000, {1'b1, 8'h2D});
        sample(7'b0001000, {1'b1, 8'h5F});
        sample(7'b1111100, {1'b1, 8'h62});
        sample(7'b0000001, {1'b0, 8'h3F});
        sample(7'b1011111, {1'b0, 8'h3F});

        // Full sweep of all 128 patterns, one per cycle.
        for (int p = 0; p < 128; p++) sample(7'(p), model(7'(p)));

        // Async reset mid-stream while '8' is displayed.
        sample(7'b1111111, {1'b1, 8'h38});
        idle(2, 7'b1111111);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_al0", {known0, ascii0}, 9'h000);
        chk("async_rst_al1", {known1, ascii1}, 9'h000);
        #1;
        rst_n = 1'b1;
        idle(3, 7'b1111111);
        sample(7'b1101111, {1'b1, 8'h39});
        idle(3, 7'b0000000);

        // Every expectation must have been retired within the bounded drain above.
        n_tests++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", expq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
